// File: rtl/bldc_duty_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bldc_duty_ramp_pkg
// Purpose : Shared BLDC types: rotation direction, ramp FSM states, driver codes.
// Rev     : 1.0  initial release
// ============================================================================
package bldc_duty_ramp_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } rotation_direction_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_RAMP      = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_WAIT_STOP = 3'd5,
    ST_FAULT     = 3'd6
  } ramp_state_t;

  localparam logic [2:0] DRV_STATE_ERROR = 3'd3;

endpackage
`default_nettype wire

// File: rtl/bldc_duty_ramp_if.sv
`default_nettype none
// ============================================================================
// Module  : bldc_duty_ramp_if
// Purpose : Host command / driver output bundle around the duty ramp stage.
// Rev     : 1.0  initial release
// ============================================================================
interface bldc_duty_ramp_if #(
  parameter int DUTY_WIDTH    = 11,
  parameter int COUNTER_WIDTH = 32
) ();
  import bldc_duty_ramp_pkg::*;

  logic                     cmd_enable;
  rotation_direction_t      cmd_direction;
  logic [DUTY_WIDTH-1:0]    cmd_duty;
  logic [DUTY_WIDTH-1:0]    pwm_cycle_ticks;
  logic [COUNTER_WIDTH-1:0] rpm;
  logic [2:0]               driver_state;
  logic                     drv_enable;
  rotation_direction_t      drv_direction;
  logic [DUTY_WIDTH-1:0]    drv_duty;
  logic [2:0]               ramp_state;
  logic                     stop_timeout;

  modport master (
    output cmd_enable, cmd_direction, cmd_duty, pwm_cycle_ticks, rpm, driver_state,
    input  drv_enable, drv_direction, drv_duty, ramp_state, stop_timeout
  );

  modport slave (
    input  cmd_enable, cmd_direction, cmd_duty, pwm_cycle_ticks, rpm, driver_state,
    output drv_enable, drv_direction, drv_duty, ramp_state, stop_timeout
  );

endinterface
`default_nettype wire

// File: rtl/bldc_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : bldc_tick_prescaler
// Purpose : Free-running divider producing a one-cycle tick every DIVIDE clocks.
// Rev     : 1.0  initial release
// ============================================================================
module bldc_tick_prescaler #(
  parameter int DIVIDE = 540
) (
  input  wire  clk,
  input  wire  reset_n,
  output logic tick
);

  localparam int CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIVIDE - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bldc_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module  : bldc_duty_ramp
// Purpose : Slew-limited duty/direction sequencer feeding the BLDC driver.
// Rev     : 1.0  initial release
// ============================================================================
module bldc_duty_ramp
  import bldc_duty_ramp_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 54_000_000,
  parameter int COUNTER_WIDTH   = 32,
  parameter int DUTY_WIDTH      = 11,
  parameter int RAMP_PERIOD_US  = 10,
  parameter int RAMP_STEP       = 4,
  parameter int STOP_RPM        = 30,
  parameter int STOP_TIMEOUT_MS = 500
) (
  input  wire              sys_clk,
  input  wire              reset_n,
  bldc_duty_ramp_if.slave  bus
);

  localparam int TICK_DIV       = CLK_FREQ_HZ / 1_000_000 * RAMP_PERIOD_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * STOP_TIMEOUT_MS;
  localparam int TMR_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DUTY_WIDTH-1:0] STEP = DUTY_WIDTH'(RAMP_STEP);

  ramp_state_t             state_q, state_d;
  logic [DUTY_WIDTH-1:0]   duty_q, duty_d;
  logic                    en_q, en_d;
  rotation_direction_t     dir_q, dir_d;
  logic                    tmo_q, tmo_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;

  logic                    tick;
  logic                    stop_req;
  logic                    same_dir;
  logic [DUTY_WIDTH-1:0]   target;
  logic [DUTY_WIDTH-1:0]   goal;
  logic [DUTY_WIDTH-1:0]   slewed;
  logic [DUTY_WIDTH-1:0]   upd;

  bldc_tick_prescaler #(.DIVIDE(TICK_DIV)) u_prescaler (
    .clk     (sys_clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    stop_req = !bus.cmd_enable || (bus.cmd_direction == DIR_NONE);
    same_dir = bus.cmd_enable && (bus.cmd_direction == dir_q);
    if (stop_req) begin
      target = '0;
    end else begin
      target = (bus.cmd_duty < bus.pwm_cycle_ticks) ? bus.cmd_duty : bus.pwm_cycle_ticks;
    end
    goal = (state_q == ST_RAMP_DOWN) ? '0 : target;
    // Step is clamped to the remaining distance so the duty never overshoots or wraps
    if (duty_q < goal) begin
      slewed = ((goal - duty_q) > STEP) ? duty_q + STEP : goal;
    end else if (duty_q > goal) begin
      slewed = ((duty_q - goal) > STEP) ? duty_q - STEP : goal;
    end else begin
      slewed = duty_q;
    end
    upd = tick ? slewed : duty_q;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    en_d    = en_q;
    dir_d   = dir_q;
    tmo_d   = tmo_q;
    tmr_d   = tmr_q;
    if (bus.driver_state == DRV_STATE_ERROR) begin
      state_d = ST_FAULT;
      duty_d  = '0;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          en_d   = 1'b0;
          if (!stop_req) begin
            dir_d   = bus.cmd_direction;
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          en_d    = 1'b1;
          state_d = ST_RAMP;
        end
        ST_RAMP: begin
          duty_d = upd;
          if (!same_dir) begin
            state_d = ST_RAMP_DOWN;
          end else if (upd == target) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!same_dir) begin
            state_d = ST_RAMP_DOWN;
          end else if (target != duty_q) begin
            state_d = ST_RAMP;
          end
        end
        ST_RAMP_DOWN: begin
          duty_d = upd;
          if (same_dir) begin
            state_d = ST_RAMP;
          end else if (upd == '0) begin
            en_d = 1'b0;
            if (stop_req) begin
              dir_d   = DIR_NONE;
              state_d = ST_IDLE;
            end else begin
              tmr_d   = '0;
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_WAIT_STOP: begin
          if (stop_req) begin
            dir_d   = DIR_NONE;
            state_d = ST_IDLE;
          end else if (bus.rpm <= COUNTER_WIDTH'(STOP_RPM)) begin
            dir_d   = bus.cmd_direction;
            state_d = ST_ARM;
          end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_FAULT: begin
          duty_d = '0;
          en_d   = 1'b0;
          if (!bus.cmd_enable) begin
            tmo_d   = 1'b0;
            dir_d   = DIR_NONE;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      en_q    <= 1'b0;
      dir_q   <= DIR_NONE;
      tmo_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      tmo_q   <= tmo_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.drv_enable    = en_q;
  assign bus.drv_direction = dir_q;
  assign bus.drv_duty      = duty_q;
  assign bus.ramp_state    = state_q;
  assign bus.stop_timeout  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_bldc_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module  : tb_bldc_duty_ramp
// Purpose : Randomised + directed bench for bldc_duty_ramp with reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bldc_duty_ramp;
  import bldc_duty_ramp_pkg::*;

  localparam int CLK_HZ  = 1_000_000;
  localparam int PER_US  = 10;
  localparam int STEP    = 4;
  localparam int SRPM    = 30;
  localparam int TMO_MS  = 2;
  localparam int DIV     = CLK_HZ / 1_000_000 * PER_US;
  localparam int TMO_CYC = CLK_HZ / 1000 * TMO_MS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bldc_duty_ramp_if #(.DUTY_WIDTH(11), .COUNTER_WIDTH(32)) bus ();

  bldc_duty_ramp #(
    .CLK_FREQ_HZ(CLK_HZ), .COUNTER_WIDTH(32), .DUTY_WIDTH(11), .RAMP_PERIOD_US(PER_US),
    .RAMP_STEP(STEP), .STOP_RPM(SRPM), .STOP_TIMEOUT_MS(TMO_MS)
  ) dut (
    .sys_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state numbers are the externally visible ramp_state codes
  int m_state = 0, m_duty = 0, m_en = 0, m_dir = 0, m_flag = 0, m_wait = 0, m_phase = 0;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int toward(input int d, input int t);
    if (d < t) return d + min2(STEP, t - d);
    if (d > t) return d - min2(STEP, d - t);
    return d;
  endfunction

  always @(posedge clk) begin : model
    int tgt, nd;
    bit tick, stop, same;
    if (!reset_n) begin
      m_state = 0; m_duty = 0; m_en = 0; m_dir = 0; m_flag = 0; m_wait = 0; m_phase = 0;
    end else begin
      tick    = (m_phase % DIV) == DIV - 1;
      m_phase = m_phase + 1;
      stop = !bus.cmd_enable || int'(bus.cmd_direction) == 0;
      tgt  = stop ? 0 : min2(int'(bus.cmd_duty), int'(bus.pwm_cycle_ticks));
      same = bus.cmd_enable && int'(bus.cmd_direction) == m_dir;
      if (bus.driver_state == 3'd3) begin
        m_state = 6; m_duty = 0; m_en = 0;
      end else if (m_state == 0) begin
        m_duty = 0; m_en = 0;
        if (!stop) begin m_dir = int'(bus.cmd_direction); m_state = 1; end
      end else if (m_state == 1) begin
        m_en = 1; m_state = 2;
      end else if (m_state == 2) begin
        nd = tick ? toward(m_duty, tgt) : m_duty;
        m_duty = nd;
        if (!same) m_state = 4;
        else if (nd == tgt) m_state = 3;
      end else if (m_state == 3) begin
        if (!same) m_state = 4;
        else if (tgt != m_duty) m_state = 2;
      end else if (m_state == 4) begin
        nd = tick ? toward(m_duty, 0) : m_duty;
        m_duty = nd;
        if (same) m_state = 2;
        else if (nd == 0) begin
          m_en = 0;
          if (stop) begin m_dir = 0; m_state = 0; end
          else begin m_wait = 0; m_state = 5; end
        end
      end else if (m_state == 5) begin
        m_wait = m_wait + 1;
        if (stop) begin m_dir = 0; m_state = 0; end
        else if (bus.rpm <= 32'(SRPM)) begin m_dir = int'(bus.cmd_direction); m_state = 1; end
        else if (m_wait == TMO_CYC) begin m_flag = 1; m_state = 6; end
      end else begin
        m_duty = 0; m_en = 0;
        if (!bus.cmd_enable) begin m_flag = 0; m_dir = 0; m_state = 0; end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("model_state", int'(bus.ramp_state), m_state);
      check("model_duty", int'(bus.drv_duty), m_duty);
      check("model_enable", int'(bus.drv_enable), m_en);
      check("model_direction", int'(bus.drv_direction), m_dir);
      check("model_timeout", int'(bus.stop_timeout), m_flag);
    end
  end

  task automatic wait_state(input int st, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(bus.ramp_state) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(bus.ramp_state), st);
  endtask

  task automatic wait_duty_at_least(input int v, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(bus.drv_duty) < v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(bus.drv_duty), v);
  endtask

  initial begin
    bus.cmd_enable      = 1'b0;
    bus.cmd_direction   = DIR_NONE;
    bus.cmd_duty        = '0;
    bus.pwm_cycle_ticks = 11'd1023;
    bus.rpm             = '0;
    bus.driver_state    = 3'd0;
    repeat (4) @(negedge clk);
    check("reset_state", int'(bus.ramp_state), 0);
    check("reset_duty", int'(bus.drv_duty), 0);
    check("reset_dir", int'(bus.drv_direction), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Forward start and ramp to 400
    bus.cmd_enable = 1'b1; bus.cmd_direction = DIR_CW; bus.cmd_duty = 11'd400;
    wait_state(1, 10, "arm_reached");
    check("dir_before_enable", int'(bus.drv_direction), 1);
    check("enable_low_in_arm", int'(bus.drv_enable), 0);
    @(negedge clk);
    check("enable_after_arm", int'(bus.drv_enable), 1);
    wait_state(3, 1100, "hold_at_400");
    check("duty_400", int'(bus.drv_duty), 400);

    // Ceiling clamp
    bus.cmd_duty = 11'd1500; bus.pwm_cycle_ticks = 11'd1002;
    @(negedge clk);
    wait_state(3, 1700, "hold_at_ceiling");
    check("duty_1002", int'(bus.drv_duty), 1002);
    bus.cmd_duty = 11'd400; bus.pwm_cycle_ticks = 11'd1023;
    @(negedge clk);
    wait_state(3, 1700, "hold_back_400");

    // Reversal with motor stopping
    bus.rpm = 32'd200; bus.cmd_direction = DIR_CCW;
    wait_state(5, 1200, "wait_stop_reached");
    check("wait_stop_enable", int'(bus.drv_enable), 0);
    check("wait_stop_duty", int'(bus.drv_duty), 0);
    repeat (50) @(negedge clk);
    bus.rpm = 32'd20;
    @(negedge clk);
    check("reversed_dir", int'(bus.drv_direction), 2);
    wait_state(3, 1200, "hold_ccw");
    check("ccw_duty_400", int'(bus.drv_duty), 400);

    // Reversal without stopping times out
    bus.rpm = 32'd200; bus.cmd_direction = DIR_CW;
    wait_state(6, 1200 + TMO_CYC + 50, "timeout_fault");
    check("stop_timeout_set", int'(bus.stop_timeout), 1);
    check("fault_duty", int'(bus.drv_duty), 0);
    bus.cmd_enable = 1'b0;
    @(negedge clk);
    check("fault_exit_idle", int'(bus.ramp_state), 0);
    check("stop_timeout_clr", int'(bus.stop_timeout), 0);

    // Driver error mid-ramp
    bus.rpm = 32'd0; bus.cmd_enable = 1'b1;
    wait_duty_at_least(200, 700, "ramp_to_200");
    bus.driver_state = 3'd3;
    @(negedge clk);
    check("err_state", int'(bus.ramp_state), 6);
    check("err_duty", int'(bus.drv_duty), 0);
    check("err_enable", int'(bus.drv_enable), 0);
    check("err_dir_held", int'(bus.drv_direction), 1);
    repeat (5) @(negedge clk);
    bus.driver_state = 3'd0;
    repeat (3) @(negedge clk);
    check("fault_held_enabled", int'(bus.ramp_state), 6);
    bus.cmd_enable = 1'b0;
    @(negedge clk);
    check("fault_to_idle", int'(bus.ramp_state), 0);

    // Reset pulse mid-ramp
    bus.cmd_enable = 1'b1;
    wait_duty_at_least(100, 500, "ramp_to_100");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_state", int'(bus.ramp_state), 0);
    check("rst_duty", int'(bus.drv_duty), 0);
    check("rst_enable", int'(bus.drv_enable), 0);
    repeat (60) @(negedge clk);

    // Randomised segments
    for (int i = 0; i < 40; i++) begin
      int r;
      bus.cmd_enable      = ($urandom_range(0, 9) < 8);
      bus.cmd_direction   = rotation_direction_t'($urandom_range(0, 2));
      bus.cmd_duty        = 11'($urandom_range(0, 2047));
      bus.pwm_cycle_ticks = 11'($urandom_range(100, 2047));
      bus.rpm             = 32'($urandom_range(0, 60));
      r = $urandom_range(0, 19);
      bus.driver_state    = (r < 2) ? 3'd3 : ((r < 10) ? 3'd0 : 3'($urandom_range(4, 7)));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      repeat ($urandom_range(20, 400)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bldc_duty_ramp.md
Name: bldc_duty_ramp

Overview:
- Command-conditioning stage directly upstream of the table-commutated BLDC driver. Produces its enable, direction and PWM duty inputs.
- Converts raw host commands into slew-limited duty changes.
- Sequences direction reversals as: ramp down, wait for measured rpm to fall, switch direction, ramp up.
- Drops the drive immediately when the driver reports its error state.

Parameters:
- clk_freq_hz, 54_000_000: sys_clk frequency.
- counter_width, 32: width of the rpm input.
- duty_width, 11: width of all duty/tick values; matches the driver pwm counter width.
- ramp_period_us, 10: interval between duty updates.
- ramp_step, 4: maximum duty change per update, in LSB.
- stop_rpm, 30: rpm at or below which the motor counts as stopped.
- stop_timeout_ms, 500: maximum time in WAIT_STOP before fault.

Ports:
- sys_clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- cmd_enable  in  1  host run request.
- cmd_direction  in  rotation_direction_t  host direction (DIR_NONE = stop).
- cmd_duty  in  duty_width  host duty target.
- pwm_cycle_ticks  in  duty_width  driver PWM period; used as duty ceiling.
- rpm  in  counter_width  measured speed from the encoder.
- driver_state  in  3  driver FSM state; value 3 = error.
- drv_enable  out  1  to driver enable.
- drv_direction  out  rotation_direction_t  to driver direction.
- drv_duty  out  duty_width  to driver pwm_duty.
- ramp_state  out  3  current FSM state encoding.
- stop_timeout  out  1  sticky; set on WAIT_STOP timeout.

Behaviour:
- All logic on posedge sys_clk. Reset is sampled synchronously and has priority over every other condition.
- Reset values: drv_enable=0, drv_direction=DIR_NONE, drv_duty=0, ramp_state=IDLE, stop_timeout=0, prescaler=0, timeout counter=0.
- Tick prescaler:
  - Free-running; wraps at clk_freq_hz/1_000_000*ramp_period_us-1.
  - Emits a 1-cycle tick on wrap (every 540 cycles at defaults).
- Target:
  - When cmd_enable=1 and cmd_direction!=DIR_NONE: target = min(cmd_duty, pwm_cycle_ticks).
  - Otherwise: target = 0.
- Duty update happens only on a tick, only in RAMP or RAMP_DOWN:
  - If drv_duty<target: drv_duty += min(ramp_step, target-drv_duty).
  - If drv_duty>target: drv_duty -= min(ramp_step, drv_duty-target).
  - Never overshoots; never wraps.
- State encoding: IDLE=0, ARM=1, RAMP=2, HOLD=3, RAMP_DOWN=4, WAIT_STOP=5, FAULT=6.
- IDLE:
  - Outputs: duty 0, enable 0.
  - If cmd_enable and cmd_direction!=DIR_NONE and driver_state!=3: latch drv_direction=cmd_direction, go to ARM.
- ARM: assert drv_enable, go to RAMP. Direction is therefore stable one cycle before enable rises.
- RAMP:
  - Slew toward target.
  - drv_duty==target (after update or on entry) -> HOLD.
  - cmd_enable=0, or cmd_direction differs from drv_direction -> RAMP_DOWN.
- HOLD:
  - drv_duty constant.
  - Target change with same direction -> RAMP.
  - Disable or direction change -> RAMP_DOWN.
- RAMP_DOWN:
  - Slew toward 0.
  - If the command returns to enable with the same direction before duty reaches 0 -> RAMP, without stopping.
  - On drv_duty==0:
    - Disabled -> IDLE, dropping drv_enable and driving drv_direction=DIR_NONE.
    - Reversal -> WAIT_STOP, dropping drv_enable and clearing the timeout counter.
- WAIT_STOP:
  - If rpm<=stop_rpm: latch drv_direction=cmd_direction, go to ARM.
  - If the command becomes disable or DIR_NONE: -> IDLE.
  - If stop_timeout_ms elapses: set stop_timeout, go to FAULT.
- FAULT:
  - Entered from any state when driver_state==3. This has priority over all other transitions in the same cycle.
  - On entry: drv_duty=0 and drv_enable=0 in the same cycle. drv_direction is held.
  - Exit to IDLE when cmd_enable==0 and driver_state!=3. Exit clears stop_timeout and sets drv_direction=DIR_NONE.
- Simultaneous tick and state transition: the duty update uses the state registered at that edge.
- pwm_cycle_ticks dropping below drv_duty: treated as a new target; duty ramps down, no step jump.

Decomposition:
- Shared bldc types package:
  - ramp_state_t enum (7 states above).
  - Driver error-state constant (3); the existing rotation_direction_t is reused.
- Sub-module bldc_tick_prescaler (parameterised divider, 1-cycle tick output). It is reusable by the encoder and the gate-reset timing.

Test Plan:
- Reset held, then cmd_enable=1, CW, cmd_duty=400:
  - drv_direction=CW one cycle before drv_enable=1.
  - drv_duty rises 4 per tick and reaches 400 after 100 ticks (54000 cycles).
  - State ends in HOLD.
- In HOLD at 400, cmd_duty=1500 with pwm_cycle_ticks=1002: ramps to exactly 1002, then HOLD.
- In HOLD at 400, cmd_direction=CCW:
  - RAMP_DOWN to 0, then WAIT_STOP with drv_enable=0.
  - rpm forced from 200 to 20: direction becomes CCW, ARM, ramp to 400.
- Reversal with rpm held at 200: after 500 ms stop_timeout=1, state FAULT, duty 0.
- In RAMP at duty 200, driver_state=3: next edge drv_duty=0, drv_enable=0, FAULT. FAULT is held until cmd_enable=0 and driver_state=0, then IDLE.
- Assert reset_n=0 mid-RAMP for one cycle: all outputs reach reset values at that edge and the prescaler restarts.
